delay_scan_controller: RTL
==========================

// Module: delay_scan_controller
// PURPOSE
//  Steps the delay-chip code through a programmed range. At each point it runs the TDC sequencer once.
//  Per point: issue a one-cycle set to the delay block, wait a settle time, pulse run_sequencer, wait for ready.
//  Sits between the SPI command decoder and the delay/sequencer pair, replacing host-driven point-by-point scans.
// PARAMETERS
//  DW        10     delay code width (matches delay-chip D bus)
//  NW        10     step-count width
//  SW        8      settle-counter width (clk cycles)
//  TIMEOUT   4096   max clk cycles waiting for ready per point; 0 = no timeout
// PORTS
//  clk           in   1   system clock (PLL c0)
//  res_n         in   1   async active-low reset (PLL locked)
//  start         in   1   one-cycle pulse: begin scan with current cfg
//  abort         in   1   one-cycle pulse: stop scan
//  cfg_first     in   DW  first delay code
//  cfg_step      in   DW  code increment per point
//  cfg_npoints   in   NW  number of points (0 = none)
//  cfg_sel       in   1   delay chip select (0=A, 1=B)
//  cfg_settle    in   SW  settle cycles after set
//  seq_ready     in   1   sequencer ready_flag
//  del_set       out  1   one-cycle set strobe to delay block
//  del_sel       out  1   chip select to delay block
//  del_d         out  DW  delay code to delay block
//  seq_run       out  1   one-cycle run_sequencer pulse
//  busy          out  1   scan in progress
//  done          out  1   one-cycle pulse at scan end (normal, abort or error)
//  err           out  2   sticky until next start: 0 ok, 1 code overflow, 2 ready timeout, 3 aborted
//  point_idx     out  NW  index of current/last point
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE.
//  - cfg_* sampled into shadow regs on accepted start. Later cfg changes have no effect until the next start.
//  - States and transitions:
//    IDLE -> PROG on start (ignored while busy).
//    PROG: del_set=1 for exactly 1 cycle, del_d/del_sel held stable from this cycle -> SETTLE.
//    SETTLE: count cfg_settle cycles (0 = go next cycle) -> TRIG.
//    TRIG: seq_run=1 for 1 cycle -> WAITLO.
//    WAITLO: wait seq_ready=0 (sequencer accepted) -> WAITHI. WAITHI: wait seq_ready=1 -> NEXT.
//    NEXT: point_idx+1. If point_idx+1==npoints -> DONE, else del_d+=step -> PROG.
//    DONE: done=1 for 1 cycle, busy=0 -> IDLE.
//  - Latency start->first del_set: 2 cycles. seq_ready high -> next del_set: 2 cycles.
//  - cfg_npoints=0: start -> DONE directly. done pulses 2 cycles after start, no set/run.
//  - Code arithmetic is DW+1 bits. A next code >2^DW-1 sets err=1 and goes to DONE. No wrap, and the overflowing point is not run.
//  - TIMEOUT!=0: waited cycles (WAITLO+WAITHI) reaching TIMEOUT -> err=2, DONE.
//  - abort in any non-IDLE state -> err=3, DONE next cycle. Pulses not yet issued are suppressed.
//  - abort and start in the same cycle: abort wins, start dropped. abort in IDLE has no effect.
//  - del_d/del_sel keep the last programmed value after the scan ends.
//  - Reset mid-scan: immediate return to IDLE, outputs 0, no done pulse.
// CONFIGURATION
//  - DELAY_SCAN_REPEAT_EN defined: adds input cfg_repeat[7:0].
//    Each point is run cfg_repeat+1 times: NEXT returns to TRIG until the repeat count is exhausted, without re-setting the delay.
//    Adds output rep_idx[7:0], reset 0.
//  - Not defined: exactly one sequencer run per point. No cfg_repeat/rep_idx ports.
// STRUCTURE
//  - Package delay_scan_pkg: state encoding localparams, err code constants (ERR_OK, ERR_OVF, ERR_TMO, ERR_ABT).
//  - One sub-module: scan_timer, a loadable down-counter shared by SETTLE and ready-timeout, with a zero flag.
//  - FSM, shadow cfg regs and code adder remain in the top.
// TESTING
//  - first=100, step=10, npoints=3, settle=4, ready model 20 cycles:
//    -> del_d 100,110,120; 3 del_set, 3 seq_run; done once; err=0; point_idx=2.
//  - npoints=0 start -> done 2 cycles later, no del_set/seq_run, err=0.
//  - first=1020, step=5, npoints=4 -> one point run at 1020, then err=1, done, del_d stays 1020.
//  - TIMEOUT=64, ready held low -> err=2 after 64 cycles in wait, done pulse, busy drops.
//  - abort during SETTLE of point 1 -> no seq_run for point 1; err=3; done next cycle.
//    A start in the same cycle as an abort is ignored.
//  - Reset asserted in WAITHI -> all outputs 0 immediately. A new start after release runs normally.
//    With DELAY_SCAN_REPEAT_EN, repeat=2, npoints=2 -> 2 del_set, 6 seq_run.

Source files
------------

// File: rtl/delay_scan_pkg.sv
// Shared definitions for the delay scan controller: FSM state encoding and error codes.
package delay_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PROG   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_TRIG   = 3'd3,
        ST_WAITLO = 3'd4,
        ST_WAITHI = 3'd5,
        ST_NEXT   = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_OVF = 2'd1;
    localparam logic [1:0] ERR_TMO = 2'd2;
    localparam logic [1:0] ERR_ABT = 2'd3;

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter with zero flag, shared by settle wait and ready timeout.
// Latency: load takes effect next cycle; zero is combinational from the count; no backpressure.
// Decrement saturates at zero.
module scan_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         res_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/delay_scan_controller.sv
// Steps the delay-chip code through a programmed range, running the TDC sequencer at each point.
// Latency: start -> first del_set 2 cycles; seq_ready high -> next del_set 2 cycles; npoints=0 -> done 2 cycles.
// Backpressure: per run waits seq_ready low then high, bounded by TIMEOUT. Option macro: DELAY_SCAN_REPEAT_EN.
module delay_scan_controller
    import delay_scan_pkg::*;
#(
    parameter int DW      = 10,
    parameter int NW      = 10,
    parameter int SW      = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          res_n,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] cfg_first,
    input  logic [DW-1:0] cfg_step,
    input  logic [NW-1:0] cfg_npoints,
    input  logic          cfg_sel,
    input  logic [SW-1:0] cfg_settle,
`ifdef DELAY_SCAN_REPEAT_EN
    input  logic [7:0]    cfg_repeat,
    output logic [7:0]    rep_idx,
`endif
    input  logic          seq_ready,
    output logic          del_set,
    output logic          del_sel,
    output logic [DW-1:0] del_d,
    output logic          seq_run,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err,
    output logic [NW-1:0] point_idx
);

    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam int TW  = (TCW > SW) ? TCW : SW;
    localparam logic [TW-1:0] TMO_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    state_t        state;
    logic [DW-1:0] sh_first;
    logic [DW-1:0] sh_step;
    logic [NW-1:0] sh_npoints;
    logic          sh_sel;
    logic [SW-1:0] sh_settle;
`ifdef DELAY_SCAN_REPEAT_EN
    logic [7:0]    sh_repeat;
`endif

    logic          tmr_load;
    logic          tmr_dec;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;
    logic          tmo_hit;
    logic          rep_more;
    logic          last_point;
    logic [NW:0]   idx_inc;
    logic [DW:0]   next_code;

    // One extra bit so an overflowing code is detected instead of wrapping.
    assign next_code  = {1'b0, del_d} + {1'b0, sh_step};
    assign idx_inc    = {1'b0, point_idx} + (NW + 1)'(1);
    assign last_point = (idx_inc == {1'b0, sh_npoints});
    assign tmo_hit    = (TIMEOUT != 0) && tmr_zero;

`ifdef DELAY_SCAN_REPEAT_EN
    assign rep_more = (rep_idx != sh_repeat);
`else
    assign rep_more = 1'b0;
`endif

    // The timer counts settle cycles after a set, then waited cycles across WAITLO+WAITHI.
    always_comb begin
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = TW'(sh_settle);
        case (state)
            ST_PROG, ST_NEXT: tmr_load = 1'b1;
            ST_TRIG: begin
                tmr_load = 1'b1;
                tmr_val  = TMO_LOAD;
            end
            ST_SETTLE, ST_WAITLO, ST_WAITHI: tmr_dec = 1'b1;
            default: ;
        endcase
    end

    scan_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .res_n    (res_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= ST_IDLE;
            sh_first   <= '0;
            sh_step    <= '0;
            sh_npoints <= '0;
            sh_sel     <= 1'b0;
            sh_settle  <= '0;
`ifdef DELAY_SCAN_REPEAT_EN
            sh_repeat  <= '0;
            rep_idx    <= '0;
`endif
            del_set    <= 1'b0;
            del_sel    <= 1'b0;
            del_d      <= '0;
            seq_run    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= ERR_OK;
            point_idx  <= '0;
        end else begin
            del_set <= 1'b0;
            seq_run <= 1'b0;
            done    <= 1'b0;
            // Abort pre-empts every pending strobe of the cycle it arrives in.
            if (abort && (state != ST_IDLE) && (state != ST_DONE)) begin
                err   <= ERR_ABT;
                state <= ST_DONE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            sh_first   <= cfg_first;
                            sh_step    <= cfg_step;
                            sh_npoints <= cfg_npoints;
                            sh_sel     <= cfg_sel;
                            sh_settle  <= cfg_settle;
`ifdef DELAY_SCAN_REPEAT_EN
                            sh_repeat  <= cfg_repeat;
                            rep_idx    <= '0;
`endif
                            err        <= ERR_OK;
                            point_idx  <= '0;
                            busy       <= 1'b1;
                            state      <= (cfg_npoints == '0) ? ST_DONE : ST_PROG;
                        end
                    end
                    ST_PROG: begin
                        del_set <= 1'b1;
                        del_d   <= sh_first;
                        del_sel <= sh_sel;
                        state   <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (tmr_zero) state <= ST_TRIG;
                    end
                    ST_TRIG: begin
                        seq_run <= 1'b1;
                        state   <= ST_WAITLO;
                    end
                    ST_WAITLO: begin
                        if (!seq_ready) begin
                            state <= ST_WAITHI;
                        end else if (tmo_hit) begin
                            err   <= ERR_TMO;
                            state <= ST_DONE;
                        end
                    end
                    ST_WAITHI: begin
                        if (seq_ready) begin
                            state <= ST_NEXT;
                        end else if (tmo_hit) begin
                            err   <= ERR_TMO;
                            state <= ST_DONE;
                        end
                    end
                    ST_NEXT: begin
                        if (rep_more) begin
`ifdef DELAY_SCAN_REPEAT_EN
                            rep_idx <= rep_idx + 8'd1;
`endif
                            state   <= ST_TRIG;
                        end else if (last_point) begin
                            state <= ST_DONE;
                        end else if (next_code[DW]) begin
                            err   <= ERR_OVF;
                            state <= ST_DONE;
                        end else begin
                            // Programs the next point directly to keep ready->set at 2 cycles.
                            point_idx <= idx_inc[NW-1:0];
                            del_d     <= next_code[DW-1:0];
                            del_set   <= 1'b1;
`ifdef DELAY_SCAN_REPEAT_EN
                            rep_idx   <= '0;
`endif
                            state     <= ST_SETTLE;
                        end
                    end
                    ST_DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
